// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit bridging the pipeline to a req/ack data bus.
// Latency: non-memory ops pass through in 0 cycles; aligned accesses take 1 + bus cycles + 1 (DONE).
// Backpressure: hold_req_o stalls the pipeline from the issue cycle until DONE; watchdog aborts after 255 bus cycles.
//
// Ports:
//   clk_100MHz, arst_n          clock, asynchronous active-low reset
//   inst_i, reg_w_*_i, rs2_*    instruction, writeback request, effective address, store data from EX/MEM
//   bus_*                       single-outstanding word bus (req/ack), word-aligned address, byte enables
//   hold_req_o                  pipeline stall request
//   misalign_o, bus_err_o       misaligned access (issue cycle) / bus timeout (DONE cycle)
//   inst_o, reg_w_*_o, mem_*_o  results toward mem_wb
module mem_access (
   input  logic        clk_100MHz,
   input  logic        arst_n,
   input  logic [31:0] inst_i,
   input  logic        reg_w_ena_i,
   input  logic [4:0]  reg_w_addr_i,
   input  logic [31:0] reg_w_data_i,
   input  logic [31:0] rs2_data_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        hold_req_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic [31:0] inst_o,
   output logic        reg_w_ena_o,
   output logic [4:0]  reg_w_addr_o,
   output logic [31:0] reg_w_data_o,
   output logic        mem_r_ena_o,
   output logic [31:0] mem_r_addr_o,
   output logic [31:0] mem_r_data_o,
   output logic        mem_w_ena_o,
   output logic [31:0] mem_w_addr_o,
   output logic [31:0] mem_w_data_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   state_t      r_state;
   logic [7:0]  r_wdog;
   logic        r_err;
   logic        r_bus_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;
   logic [4:0]  r_rd;
   logic        r_rd_ena;
   logic [31:0] r_inst;
   logic [31:0] r_rs2;
   logic [31:0] r_rdata;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [31:0] w_addr;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic        w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   assign w_opcode = inst_i[6:0];
   assign w_funct3 = inst_i[14:12];
   assign w_addr   = reg_w_data_i;

   // Unsupported funct3 encodings under the load/store opcodes fall through as non-memory ops.
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      if (w_opcode == OPC_LOAD) begin
         case (w_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_is_load = 1'b1;
            default:                                w_is_load = 1'b0;
         endcase
      end
      if (w_opcode == OPC_STORE) begin
         case (w_funct3)
            3'b000, 3'b001, 3'b010: w_is_store = 1'b1;
            default:                w_is_store = 1'b0;
         endcase
      end
   end

   assign w_is_mem = w_is_load | w_is_store;

   // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word.
   always_comb begin
      w_misalign = 1'b0;
      w_be       = 4'b1111;
      w_wdata    = rs2_data_i;
      case (w_funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_wdata = {4{rs2_data_i[7:0]}};
         end
         2'b01: begin
            w_misalign = w_addr[0];
            w_be       = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{rs2_data_i[15:0]}};
         end
         default: begin
            w_misalign = (w_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Lane selection and extension of the captured read word.
   always_comb begin
      case (r_addr[1:0])
         2'd1:    w_byte = r_rdata[15:8];
         2'd2:    w_byte = r_rdata[23:16];
         2'd3:    w_byte = r_rdata[31:24];
         default: w_byte = r_rdata[7:0];
      endcase
      w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = r_rdata;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         r_state   <= S_IDLE;
         r_wdog    <= 8'd0;
         r_err     <= 1'b0;
         r_bus_req <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'd0;
         r_be      <= 4'd0;
         r_wdata   <= 32'd0;
         r_funct3  <= 3'd0;
         r_rd      <= 5'd0;
         r_rd_ena  <= 1'b0;
         r_inst    <= 32'd0;
         r_rs2     <= 32'd0;
         r_rdata   <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_mem && !w_misalign) begin
                  r_we      <= w_is_store;
                  r_addr    <= w_addr;
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_funct3  <= w_funct3;
                  r_rd      <= reg_w_addr_i;
                  r_rd_ena  <= reg_w_ena_i;
                  r_inst    <= inst_i;
                  r_rs2     <= rs2_data_i;
                  r_wdog    <= 8'd0;
                  r_err     <= 1'b0;
                  r_bus_req <= 1'b1;
                  r_state   <= S_BUS;
               end
            end
            S_BUS: begin
               if (bus_ack_i) begin
                  r_rdata   <= bus_rdata_i;
                  r_wdog    <= 8'd0;
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
               end else if (r_wdog == 8'd254) begin
                  // This cycle takes the count to 255: 255 request cycles in total, then abort.
                  r_wdog    <= 8'd255;
                  r_err     <= 1'b1;
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_wdog <= r_wdog + 8'd1;
               end
            end
            S_DONE: begin
               r_wdog  <= 8'd0;
               r_state <= S_IDLE;
            end
            default: begin
               r_bus_req <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_req_o   = r_bus_req;
   assign bus_we_o    = r_we;
   assign bus_addr_o  = {r_addr[31:2], 2'b00};
   assign bus_be_o    = r_be;
   assign bus_wdata_o = r_wdata;
   assign bus_err_o   = (r_state == S_DONE) & r_err;

   always_comb begin
      inst_o       = inst_i;
      reg_w_ena_o  = reg_w_ena_i;
      reg_w_addr_o = reg_w_addr_i;
      reg_w_data_o = reg_w_data_i;
      mem_r_ena_o  = 1'b0;
      mem_r_addr_o = 32'd0;
      mem_r_data_o = 32'd0;
      mem_w_ena_o  = 1'b0;
      mem_w_addr_o = 32'd0;
      mem_w_data_o = 32'd0;
      hold_req_o   = 1'b0;
      misalign_o   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // The combinational stall/misalign flags are gated by reset so they are quiet while held.
            if (w_is_mem) begin
               reg_w_ena_o = 1'b0;
               if (w_misalign) misalign_o = arst_n;
               else            hold_req_o = arst_n;
            end
         end
         S_BUS: begin
            inst_o       = r_inst;
            reg_w_ena_o  = 1'b0;
            reg_w_addr_o = r_rd;
            reg_w_data_o = r_addr;
            hold_req_o   = 1'b1;
         end
         S_DONE: begin
            inst_o       = r_inst;
            reg_w_addr_o = r_rd;
            reg_w_ena_o  = 1'b0;
            if (r_we) begin
               reg_w_data_o = r_addr;
               mem_w_ena_o  = ~r_err;
               mem_w_addr_o = r_addr;
               mem_w_data_o = r_rs2;
            end else begin
               reg_w_data_o = w_load_data;
               reg_w_ena_o  = r_rd_ena & ~r_err;
               mem_r_ena_o  = ~r_err;
               mem_r_addr_o = r_addr;
               mem_r_data_o = w_load_data;
            end
         end
         default: begin
            hold_req_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized bench with queue scoreboard for mem_access.
// Driver issues instructions and plays bus slave; monitor pops expectations on bus requests and retirements.
// Retirement is any cycle with hold_req_o low; each issued instruction retires exactly once.
module tb_mem_access;

   logic        clk_100MHz = 1'b0;
   logic        arst_n;
   logic [31:0] inst_i;
   logic        reg_w_ena_i;
   logic [4:0]  reg_w_addr_i;
   logic [31:0] reg_w_data_i;
   logic [31:0] rs2_data_i;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        hold_req_o;
   logic        misalign_o;
   logic        bus_err_o;
   logic [31:0] inst_o;
   logic        reg_w_ena_o;
   logic [4:0]  reg_w_addr_o;
   logic [31:0] reg_w_data_o;
   logic        mem_r_ena_o;
   logic [31:0] mem_r_addr_o;
   logic [31:0] mem_r_data_o;
   logic        mem_w_ena_o;
   logic [31:0] mem_w_addr_o;
   logic [31:0] mem_w_data_o;

   always #5 clk_100MHz = ~clk_100MHz;

   mem_access dut (
      .clk_100MHz   (clk_100MHz),
      .arst_n       (arst_n),
      .inst_i       (inst_i),
      .reg_w_ena_i  (reg_w_ena_i),
      .reg_w_addr_i (reg_w_addr_i),
      .reg_w_data_i (reg_w_data_i),
      .rs2_data_i   (rs2_data_i),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_be_o     (bus_be_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_ack_i    (bus_ack_i),
      .bus_rdata_i  (bus_rdata_i),
      .hold_req_o   (hold_req_o),
      .misalign_o   (misalign_o),
      .bus_err_o    (bus_err_o),
      .inst_o       (inst_o),
      .reg_w_ena_o  (reg_w_ena_o),
      .reg_w_addr_o (reg_w_addr_o),
      .reg_w_data_o (reg_w_data_o),
      .mem_r_ena_o  (mem_r_ena_o),
      .mem_r_addr_o (mem_r_addr_o),
      .mem_r_data_o (mem_r_data_o),
      .mem_w_ena_o  (mem_w_ena_o),
      .mem_w_addr_o (mem_w_addr_o),
      .mem_w_data_o (mem_w_data_o)
   );

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  rd;
      logic        wena;
      logic [31:0] wdata;
      logic        rena;
      logic [31:0] raddr;
      logic [31:0] rdata;
      logic        mwena;
      logic [31:0] maddr;
      logic [31:0] mdata;
      logic        mis;
      logic        err;
      logic        chk_id;
      logic        chk_data;
      int          hold;
   } ret_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          len;
   } bus_t;

   ret_t rq[$];
   bus_t bq[$];
   int   checks   = 0;
   int   failures = 0;
   logic mon_en   = 1'b0;
   logic ack_hi   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations when the DUT starts a bus access and when an instruction retires.
   initial begin
      int   hold_run;
      int   bus_run;
      logic prev_bus;
      logic unstable;
      logic have_cur;
      bus_t cur;
      ret_t r;
      hold_run = 0; bus_run = 0; prev_bus = 1'b0; unstable = 1'b0; have_cur = 1'b0;
      forever begin
         @(negedge clk_100MHz or negedge arst_n);
         if (!arst_n) begin
            hold_run = 0; bus_run = 0; prev_bus = 1'b0; have_cur = 1'b0;
         end else if (mon_en) begin
            if (bus_req_o) begin
               if (!prev_bus) begin
                  checks++;
                  if (bq.size() == 0) begin
                     failures++;
                     have_cur = 1'b0;
                     $display("FAIL bus_unexpected: bus_req_o=1 with no access pending, expected 0 at %0t", $time);
                  end else begin
                     cur = bq.pop_front();
                     have_cur = 1'b1; bus_run = 0; unstable = 1'b0;
                     chk("bus_we", 32'(bus_we_o), 32'(cur.we));
                     chk("bus_addr", bus_addr_o, cur.addr);
                     if (cur.we) begin
                        chk("bus_be", 32'(bus_be_o), 32'(cur.be));
                        chk("bus_wdata", bus_wdata_o, cur.wdata);
                     end
                  end
               end else if (have_cur && (bus_we_o !== cur.we || bus_addr_o !== cur.addr ||
                        (cur.we && (bus_be_o !== cur.be || bus_wdata_o !== cur.wdata)))) begin
                  unstable = 1'b1;
               end
               bus_run++;
               chk("hold_during_bus", 32'(hold_req_o), 32'd1);
            end else if (prev_bus && have_cur) begin
               chk("bus_req_len", 32'(bus_run), 32'(cur.len));
               chk("bus_stable", 32'(unstable), 32'd0);
               have_cur = 1'b0;
            end
            prev_bus = bus_req_o;

            if (hold_req_o) begin
               hold_run++;
            end else begin
               checks++;
               if (rq.size() == 0) begin
                  failures++;
                  $display("FAIL retire_unexpected: retirement with nothing issued, expected none at %0t", $time);
               end else begin
                  r = rq.pop_front();
                  chk("misalign", 32'(misalign_o), 32'(r.mis));
                  chk("reg_w_ena", 32'(reg_w_ena_o), 32'(r.wena));
                  chk("mem_w_ena", 32'(mem_w_ena_o), 32'(r.mwena));
                  chk("hold_cycles", 32'(hold_run), 32'(r.hold));
                  if (!r.mis) begin
                     chk("mem_r_ena", 32'(mem_r_ena_o), 32'(r.rena));
                     chk("bus_err", 32'(bus_err_o), 32'(r.err));
                  end
                  if (r.chk_id) begin
                     chk("inst_o", inst_o, r.inst);
                     chk("reg_w_addr", 32'(reg_w_addr_o), 32'(r.rd));
                  end
                  if (r.chk_data) chk("reg_w_data", reg_w_data_o, r.wdata);
                  if (r.rena) begin
                     chk("mem_r_addr", mem_r_addr_o, r.raddr);
                     chk("mem_r_data", mem_r_data_o, r.rdata);
                  end
                  if (r.mwena) begin
                     chk("mem_w_addr", mem_w_addr_o, r.maddr);
                     chk("mem_w_data", mem_w_data_o, r.mdata);
                  end
               end
               hold_run = 0;
            end
         end
      end
   end

   // Issue one instruction: compute the expected outcome from the ISA rules, drive it, and play bus
   // slave until it retires. delay=0 means the bus never acknowledges.
   task automatic issue(input logic [31:0] inst, input logic ena, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] rs2, input int delay,
                        input logic [31:0] rdata);
      ret_t        r;
      bus_t        b;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        ld, st, mis, fin;
      int          sz, off, bcnt;
      logic [31:0] mask, v;
      opc  = inst[6:0];
      f3   = inst[14:12];
      ld   = (opc == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      st   = (opc == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
      sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off  = int'(addr[1:0]) & (4 - sz);
      mis  = (ld || st) && ((int'(addr[1:0]) % sz) != 0);
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = (rdata >> (8 * off)) & mask;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;

      b.we   = st;
      b.addr = {addr[31:2], 2'b00};
      b.be   = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8 * i +: 8] = rs2[8 * (i % sz) +: 8];
      b.len  = (delay == 0) ? 255 : delay;

      r.inst = inst; r.rd = rd; r.wena = 1'b0; r.wdata = 32'd0;
      r.rena = 1'b0; r.raddr = 32'd0; r.rdata = 32'd0;
      r.mwena = 1'b0; r.maddr = 32'd0; r.mdata = 32'd0;
      r.mis = 1'b0; r.err = 1'b0; r.chk_id = 1'b0; r.chk_data = 1'b0; r.hold = 0;
      if (!(ld || st)) begin
         r.chk_id = 1'b1; r.chk_data = 1'b1; r.wena = ena; r.wdata = addr;
      end else if (mis) begin
         r.mis = 1'b1;
      end else begin
         r.chk_id = 1'b1;
         r.hold   = b.len + 1;
         if (delay == 0) begin
            r.err = 1'b1;
         end else if (ld) begin
            r.wena = ena; r.chk_data = 1'b1; r.wdata = v;
            r.rena = 1'b1; r.raddr = addr; r.rdata = v;
         end else begin
            r.mwena = 1'b1; r.maddr = addr; r.mdata = rs2;
         end
         bq.push_back(b);
      end
      rq.push_back(r);

      inst_i = inst; reg_w_ena_i = ena; reg_w_addr_i = rd; reg_w_data_i = addr; rs2_data_i = rs2;
      bcnt = 0;
      fin  = 1'b0;
      for (int c = 0; c < 600 && !fin; c++) begin
         @(negedge clk_100MHz);
         fin = !hold_req_o;
         if (bus_req_o) begin
            bcnt++;
            bus_ack_i   = (delay != 0 && bcnt == delay);
            bus_rdata_i = bus_ack_i ? rdata : $urandom;
         end else begin
            // Stray acks outside a bus access must be ignored by the DUT.
            bus_ack_i   = ack_hi | ($urandom_range(0, 3) == 0);
            bus_rdata_i = $urandom;
         end
         @(posedge clk_100MHz);
         #1;
      end
      bus_ack_i = 1'b0;
      checks++;
      if (!fin) begin
         failures++;
         $display("FAIL retire_timeout: instruction %h not retired within 600 cycles, expected retirement", inst);
      end
   endtask

   task automatic rand_issue();
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [31:0] inst, addr;
      int          delay;
      opc = 7'b0110011;
      f3  = 3'd0;
      case ($urandom_range(0, 9))
         0, 1: begin
            case ($urandom_range(0, 3))
               0:       opc = 7'b0110011;
               1:       opc = 7'b0010011;
               2:       opc = 7'b0110111;
               default: opc = 7'b1100011;
            endcase
            f3 = 3'($urandom);
         end
         2, 3, 4, 5: begin
            opc = 7'b0000011;
            case ($urandom_range(0, 4))
               0:       f3 = 3'd0;
               1:       f3 = 3'd1;
               2:       f3 = 3'd2;
               3:       f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end
         6, 7, 8: begin
            opc = 7'b0100011;
            f3  = 3'($urandom_range(0, 2));
         end
         default: begin
            if ($urandom_range(0, 1) == 1) begin
               opc = 7'b0000011;
               case ($urandom_range(0, 2))
                  0:       f3 = 3'd3;
                  1:       f3 = 3'd6;
                  default: f3 = 3'd7;
               endcase
            end else begin
               opc = 7'b0100011;
               f3  = 3'($urandom_range(3, 7));
            end
         end
      endcase
      inst = $urandom;
      inst[14:12] = f3;
      inst[6:0]   = opc;
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
         if (f3[1:0] == 2'd2)      addr[1:0] = 2'b00;
         else if (f3[1:0] == 2'd1) addr[0]   = 1'b0;
      end
      delay = ($urandom_range(0, 49) == 0) ? 0 : $urandom_range(1, 6);
      issue(inst, 1'($urandom), 5'($urandom), addr, $urandom, delay, $urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
      $fatal(1, "global timeout");
   end

   initial begin
      bus_t rb;
      arst_n = 1'b0;
      inst_i = 32'd0; reg_w_ena_i = 1'b0; reg_w_addr_i = 5'd0; reg_w_data_i = 32'd0;
      rs2_data_i = 32'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
      #12;
      chk("rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_hold", 32'(hold_req_o), 32'd0);
      chk("rst_misalign", 32'(misalign_o), 32'd0);
      chk("rst_bus_err", 32'(bus_err_o), 32'd0);
      chk("rst_bus_we", 32'(bus_we_o), 32'd0);
      chk("rst_bus_addr", bus_addr_o, 32'd0);
      chk("rst_bus_be", 32'(bus_be_o), 32'd0);

      @(posedge clk_100MHz);
      #1;
      arst_n = 1'b1;
      mon_en = 1'b1;

      // LB at 0x1003, ack on second bus cycle, top byte 0x80 -> sign-extended 0xFFFFFF80.
      issue({17'd0, 3'b000, 5'd5, 7'b0000011}, 1'b1, 5'd5, 32'h0000_1003, $urandom, 2,
            {8'h80, 24'($urandom)});
      // SH at 0x2002: upper halfword lanes, data replicated.
      issue({17'd0, 3'b001, 5'd0, 7'b0100011}, 1'b1, 5'd9, 32'h0000_2002, 32'h1234_ABCD, 1, $urandom);
      // LW at 0x6: misaligned, no bus access.
      issue({17'd0, 3'b010, 5'd3, 7'b0000011}, 1'b1, 5'd3, 32'h0000_0006, $urandom, 1, $urandom);
      // LHU at 0x2 with no ack: watchdog timeout.
      issue({17'd0, 3'b101, 5'd4, 7'b0000011}, 1'b1, 5'd4, 32'h0000_0002, $urandom, 0, $urandom);
      // ADD: pure pass-through.
      issue({7'd0, 5'd2, 5'd1, 3'b000, 5'd6, 7'b0110011}, 1'b1, 5'd6, 32'hDEAD_BEEF, $urandom, 1, $urandom);

      // Reset in the middle of a bus access, then an ack-saturated ADD afterwards.
      inst_i = {17'd0, 3'b010, 5'd7, 7'b0000011};
      reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd7; reg_w_data_i = 32'h0000_0100; rs2_data_i = $urandom;
      rb.we = 1'b0; rb.addr = 32'h0000_0100; rb.be = 4'b1111; rb.wdata = 32'd0; rb.len = 0;
      bq.push_back(rb);
      bus_ack_i = 1'b0;
      @(negedge clk_100MHz);
      @(posedge clk_100MHz);
      #1;
      @(negedge clk_100MHz);
      chk("mid_bus_req_before_rst", 32'(bus_req_o), 32'd1);
      @(posedge clk_100MHz);
      #1;
      @(negedge clk_100MHz);
      #2;
      arst_n = 1'b0;
      #1;
      chk("mid_rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("mid_rst_hold", 32'(hold_req_o), 32'd0);
      chk("mid_rst_bus_err", 32'(bus_err_o), 32'd0);
      @(posedge clk_100MHz);
      #1;
      ack_hi = 1'b1;
      arst_n = 1'b1;
      issue({7'd0, 5'd3, 5'd4, 3'b000, 5'd8, 7'b0110011}, 1'b1, 5'd8, 32'h0BAD_F00D, $urandom, 1, $urandom);
      issue({7'd0, 5'd3, 5'd4, 3'b000, 5'd9, 7'b0110011}, 1'b0, 5'd9, 32'h1357_9BDF, $urandom, 1, $urandom);
      ack_hi = 1'b0;

      for (int n = 0; n < 150; n++) rand_issue();

      mon_en = 1'b0;
      chk("retire_queue_empty", 32'(rq.size()), 32'd0);
      chk("bus_queue_empty", 32'(bq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have: clk_100MHz  in  1  clock; arst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: inst_i  in  32  instruction from EX/MEM; reg_w_ena_i  in  1; reg_w_addr_i  in  5; reg_w_data_i  in  32  ALU result / effective address; rs2_data_i  in  32  store data.
REQ-003 SHALL have: bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  32  word-aligned; bus_be_o  out  4  byte enables; bus_wdata_o  out  32; bus_ack_i  in  1; bus_rdata_i  in  32.
REQ-004 SHALL have: hold_req_o  out  1  pipeline stall request; misalign_o  out  1; bus_err_o  out  1.
REQ-005 SHALL have, toward mem_wb: inst_o 32; reg_w_ena_o 1; reg_w_addr_o 5; reg_w_data_o 32; mem_r_ena_o 1; mem_r_addr_o 32; mem_r_data_o 32; mem_w_ena_o 1; mem_w_addr_o 32; mem_w_data_o 32.

Function
REQ-006 SHALL decode load as opcode 0000011 (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU) and store as opcode 0100011 (000 SB, 001 SH, 010 SW); other funct3 values SHALL be treated as non-memory.
REQ-007 SHALL implement FSM IDLE, BUS, DONE; reset state IDLE.
REQ-008 IDLE, non-memory inst: outputs pass through combinationally (inst, reg_w_*); mem_*_ena_o=0; hold_req_o=0; stay IDLE.
REQ-009 IDLE, misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus access; misalign_o=1 that cycle; reg_w_ena_o=0; mem_w_ena_o=0; stay IDLE.
REQ-010 IDLE, aligned memory inst: hold_req_o=1 combinationally; register addr, be, wdata, we, funct3, reg_w_addr; go to BUS.
REQ-011 BUS: bus_req_o=1 with stable bus_we_o/addr/be/wdata; hold_req_o=1; 8-bit watchdog increments each cycle.
REQ-012 BUS, bus_ack_i=1 sampled: capture bus_rdata_i; clear watchdog; go to DONE.
REQ-013 BUS, watchdog reaching 255 without ack: go to DONE with error flag set; bus_req_o deasserts.
REQ-014 DONE (exactly one cycle): hold_req_o=0; outputs present the completed access; bus_err_o=error flag; then unconditionally go to IDLE; no new access starts in DONE.
REQ-015 Load result: LB/LBU select byte lane addr[1:0], LH/LHU select halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; result on reg_w_data_o and mem_r_data_o; mem_r_ena_o=1; mem_r_addr_o=effective address; reg_w_ena_o=reg_w_ena_i.
REQ-016 Store: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011 or 1100 per addr[1], wdata=halfword replicated x2; SW be=1111; in DONE mem_w_ena_o=1, mem_w_addr_o=effective address, mem_w_data_o=rs2_data_i; reg_w_ena_o=0.
REQ-017 On error: reg_w_ena_o=0, mem_r_ena_o=0, mem_w_ena_o=0 in DONE.
REQ-018 bus_addr_o SHALL be effective address with bits [1:0] forced to 0.
REQ-019 bus_ack_i outside BUS SHALL be ignored.

Reset
REQ-020 arst_n low SHALL immediately force IDLE, watchdog 0, error flag 0, bus_req_o=0, hold_req_o=0, misalign_o=0, bus_err_o=0, all registered access fields 0.
REQ-021 Reset mid-BUS SHALL abandon the access; no DONE cycle follows release.
REQ-022 After release, first clk_100MHz edge SHALL evaluate from IDLE.

Verification
REQ-023 LB, addr 0x0000_1003, ack after 2 cycles with rdata 0x80xx_xxxx -> bus_addr_o=0x1000, reg_w_data_o=0xFFFF_FF80 in DONE, hold_req_o high 3 cycles.
REQ-024 SH, addr 0x0000_2002, rs2=0x1234_ABCD -> bus_be_o=1100, bus_wdata_o=0xABCD_ABCD, bus_we_o=1, mem_w_ena_o=1 in DONE, reg_w_ena_o=0.
REQ-025 LW at 0x0000_0006 -> misalign_o=1 one cycle, bus_req_o never asserted, hold_req_o=0.
REQ-026 LHU at 0x0000_0002, bus_ack_i never asserted -> bus_req_o high 255 cycles, DONE with bus_err_o=1, reg_w_ena_o=0.
REQ-027 arst_n pulsed low during BUS, ack arriving afterward -> bus_req_o=0 immediately, ack ignored, state IDLE, no writeback.
REQ-028 ADD (opcode 0110011) -> reg_w_* pass through same cycle, hold_req_o=0, bus_req_o=0.
